// File: rtl/rv32i_pkg.sv
// Shared RV32I pipeline definitions: datapath width, canonical NOP,
// register-field bit positions and the fetch FSM state encoding.
package rv32i_pkg;

  localparam int unsigned XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int unsigned RD_LSB  = 7;
  localparam int unsigned RD_MSB  = 11;
  localparam int unsigned RS1_LSB = 15;
  localparam int unsigned RS1_MSB = 19;
  localparam int unsigned RS2_LSB = 20;
  localparam int unsigned RS2_MSB = 24;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FETCH = 2'b01,
    S_HOLD  = 2'b10,
    S_DROP  = 2'b11
  } fetch_state_e;

endpackage

// File: rtl/if_id_register.sv
// Generic pipeline register holding {pc, instr, valid}. Flush inserts a NOP
// bubble; hold keeps all fields; otherwise the inputs are captured.
module if_id_register #(
  parameter int unsigned XLEN      = rv32i_pkg::XLEN,
  parameter logic [31:0] NOP_INSTR = rv32i_pkg::NOP_INSTR
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            hold_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [31:0]     instr_i,
  input  logic            valid_i,
  output logic [XLEN-1:0] pc_o,
  output logic [31:0]     instr_o,
  output logic            valid_o
);

  logic [XLEN-1:0] pc_q;
  logic [31:0]     instr_q;
  logic            valid_q;

  // Flush overrides hold so a redirect squashes even a stalled entry.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (!hold_i) begin
      pc_q    <= pc_i;
      instr_q <= instr_i;
      valid_q <= valid_i;
    end
  end

  assign pc_o    = pc_q;
  assign instr_o = instr_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC register, imem request handshake and IF/ID.
//   state   | meaning
//   S_IDLE  | first cycle out of reset, no request
//   S_FETCH | request at PC outstanding, waiting for ready
//   S_HOLD  | response captured while front end frozen, held in buffer
//   S_DROP  | redirect seen mid-request, discard the old response
module fetch_stage #(
  parameter int unsigned     XLEN      = rv32i_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = rv32i_pkg::NOP_INSTR
) (
  input  logic            ip_clk,
  input  logic            ip_rst,
  input  logic            ip_Stall,
  input  logic            ip_PC_Hold,
  input  logic            ip_Branch_Taken,
  input  logic [XLEN-1:0] ip_Branch_Target,
  output logic            op_Imem_Req,
  output logic [XLEN-1:0] op_Imem_Addr,
  input  logic            ip_Imem_Ready,
  input  logic [31:0]     ip_Imem_Data,
  output logic [XLEN-1:0] op_IF_ID_PC,
  output logic [31:0]     op_IF_ID_Instr,
  output logic            op_IF_ID_Valid,
  output logic [4:0]      op_IF_ID_RegisterRS1,
  output logic [4:0]      op_IF_ID_RegisterRS2
);

  import rv32i_pkg::*;

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     buf_q, buf_d;
  logic [XLEN-1:0] redir_q, redir_d;

  logic            ifid_hold;
  logic            ifid_flush;
  logic [XLEN-1:0] ifid_pc_d;
  logic [31:0]     ifid_instr_d;
  logic            ifid_valid_d;

  logic            front_hold;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] pc_inc;

  assign front_hold = ip_Stall | ip_PC_Hold;
  assign br_target  = ip_Branch_Target & ALIGN_MASK;
  assign pc_inc     = pc_q + XLEN'(4);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    buf_d        = buf_q;
    redir_d      = redir_q;
    op_Imem_Req  = 1'b0;
    ifid_flush   = 1'b0;
    ifid_hold    = ip_Stall;
    ifid_pc_d    = pc_q;
    ifid_instr_d = NOP_INSTR;
    ifid_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        if (ip_Branch_Taken) begin
          pc_d       = br_target;
          ifid_flush = 1'b1;
        end
      end

      S_FETCH: begin
        op_Imem_Req = 1'b1;
        if (ip_Branch_Taken) begin
          ifid_flush = 1'b1;
          buf_d      = '0;
          if (ip_Imem_Ready) begin
            pc_d = br_target;
          end else begin
            // PC must stay put: the address is frozen until ready.
            redir_d = br_target;
            state_d = S_DROP;
          end
        end else if (ip_Imem_Ready) begin
          if (front_hold) begin
            // PC is left pointing at the buffered word; it advances on release.
            buf_d   = ip_Imem_Data;
            state_d = S_HOLD;
          end else begin
            ifid_instr_d = ip_Imem_Data;
            ifid_valid_d = 1'b1;
            pc_d         = pc_inc;
          end
        end
      end

      S_HOLD: begin
        if (ip_Branch_Taken) begin
          ifid_flush = 1'b1;
          buf_d      = '0;
          pc_d       = br_target;
          state_d    = S_FETCH;
        end else if (!front_hold) begin
          ifid_instr_d = buf_q;
          ifid_valid_d = 1'b1;
          buf_d        = '0;
          pc_d         = pc_inc;
          state_d      = S_FETCH;
        end
      end

      S_DROP: begin
        op_Imem_Req = 1'b1;
        if (ip_Branch_Taken) begin
          ifid_flush = 1'b1;
          redir_d    = br_target;
        end
        if (ip_Imem_Ready) begin
          pc_d    = ip_Branch_Taken ? br_target : redir_q;
          redir_d = '0;
          state_d = S_FETCH;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ip_clk) begin
    if (ip_rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC & ALIGN_MASK;
      buf_q   <= '0;
      redir_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
      redir_q <= redir_d;
    end
  end

  if_id_register #(
    .XLEN      (XLEN),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk_i   (ip_clk),
    .rst_i   (ip_rst),
    .hold_i  (ifid_hold),
    .flush_i (ifid_flush),
    .pc_i    (ifid_pc_d),
    .instr_i (ifid_instr_d),
    .valid_i (ifid_valid_d),
    .pc_o    (op_IF_ID_PC),
    .instr_o (op_IF_ID_Instr),
    .valid_o (op_IF_ID_Valid)
  );

  assign op_Imem_Addr         = pc_q;
  assign op_IF_ID_RegisterRS1 = op_IF_ID_Instr[RS1_MSB:RS1_LSB];
  assign op_IF_ID_RegisterRS2 = op_IF_ID_Instr[RS2_MSB:RS2_LSB];

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized run checked
// against an in-order instruction-stream model and an address-hashed memory.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        ip_clk, ip_rst, ip_Stall, ip_PC_Hold, ip_Branch_Taken, ip_Imem_Ready;
  logic [31:0] ip_Branch_Target, ip_Imem_Data;
  logic        op_Imem_Req, op_IF_ID_Valid;
  logic [31:0] op_Imem_Addr, op_IF_ID_PC, op_IF_ID_Instr;
  logic [4:0]  op_IF_ID_RegisterRS1, op_IF_ID_RegisterRS2;

  int n_total = 0;
  int n_pass  = 0;

  fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0013)) dut (
    .ip_clk               (ip_clk),
    .ip_rst               (ip_rst),
    .ip_Stall             (ip_Stall),
    .ip_PC_Hold           (ip_PC_Hold),
    .ip_Branch_Taken      (ip_Branch_Taken),
    .ip_Branch_Target     (ip_Branch_Target),
    .op_Imem_Req          (op_Imem_Req),
    .op_Imem_Addr         (op_Imem_Addr),
    .ip_Imem_Ready        (ip_Imem_Ready),
    .ip_Imem_Data         (ip_Imem_Data),
    .op_IF_ID_PC          (op_IF_ID_PC),
    .op_IF_ID_Instr       (op_IF_ID_Instr),
    .op_IF_ID_Valid       (op_IF_ID_Valid),
    .op_IF_ID_RegisterRS1 (op_IF_ID_RegisterRS1),
    .op_IF_ID_RegisterRS2 (op_IF_ID_RegisterRS2)
  );

  always #5 ip_clk = ~ip_clk;

  // Memory contents: each address maps to a distinct word.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // Drive one cycle of inputs (called just after an edge), then advance.
  task automatic step(input logic rdy, input logic st, input logic ph,
                      input logic br, input logic [31:0] tgt);
    ip_Imem_Ready    = rdy;
    ip_Stall         = st;
    ip_PC_Hold       = ph;
    ip_Branch_Taken  = br;
    ip_Branch_Target = tgt;
    ip_Imem_Data     = rdy ? mem_word(op_Imem_Addr) : 32'hDEAD_BEEF;
    @(posedge ip_clk);
    #1;
    ip_Branch_Taken  = 1'b0;
  endtask

  task automatic do_reset();
    ip_rst = 1'b1;
    ip_Stall = 1'b0; ip_PC_Hold = 1'b0; ip_Branch_Taken = 1'b0;
    ip_Imem_Ready = 1'b0; ip_Branch_Target = '0; ip_Imem_Data = '0;
    repeat (2) @(posedge ip_clk);
    #1;
    ip_rst = 1'b0;
  endtask

  task automatic test_reset();
    ip_rst = 1'b1;
    ip_Stall = 1'b0; ip_PC_Hold = 1'b0; ip_Branch_Taken = 1'b0;
    ip_Imem_Ready = 1'b1; ip_Branch_Target = '0; ip_Imem_Data = '0;
    repeat (3) @(posedge ip_clk);
    #1;
    n_total++; if (op_Imem_Req !== 1'b0) $display("FAIL rst_req got %0h exp 0", op_Imem_Req); else n_pass++;
    n_total++; if (op_Imem_Addr !== 32'h0) $display("FAIL rst_addr got %h exp 00000000", op_Imem_Addr); else n_pass++;
    n_total++; if (op_IF_ID_Valid !== 1'b0) $display("FAIL rst_valid got %0h exp 0", op_IF_ID_Valid); else n_pass++;
    n_total++; if (op_IF_ID_Instr !== NOP) $display("FAIL rst_instr got %h exp %h", op_IF_ID_Instr, NOP); else n_pass++;
    n_total++; if (op_IF_ID_PC !== 32'h0) $display("FAIL rst_pc got %h exp 00000000", op_IF_ID_PC); else n_pass++;
    ip_rst = 1'b0;
    // First cycle after release is idle: still no request.
    n_total++; if (op_Imem_Req !== 1'b0) $display("FAIL idle_req got %0h exp 0", op_Imem_Req); else n_pass++;
  endtask

  task automatic test_zero_wait();
    logic [31:0] w;
    do_reset();
    step(1, 0, 0, 0, 0);
    n_total++; if (op_Imem_Req !== 1'b1 || op_Imem_Addr !== 32'd0) $display("FAIL zw_first_req got req=%0h addr=%h exp req=1 addr=00000000", op_Imem_Req, op_Imem_Addr); else n_pass++;
    n_total++; if (op_IF_ID_Valid !== 1'b0) $display("FAIL zw_first_valid got %0h exp 0", op_IF_ID_Valid); else n_pass++;
    for (int k = 1; k <= 3; k++) begin
      step(1, 0, 0, 0, 0);
      w = mem_word(32'(4 * (k - 1)));
      n_total++; if (op_Imem_Addr !== 32'(4 * k)) $display("FAIL zw_addr got %h exp %h", op_Imem_Addr, 32'(4 * k)); else n_pass++;
      n_total++; if (op_IF_ID_Valid !== 1'b1 || op_IF_ID_PC !== 32'(4 * (k - 1)) || op_IF_ID_Instr !== w)
        $display("FAIL zw_ifid got v=%0h pc=%h i=%h exp v=1 pc=%h i=%h", op_IF_ID_Valid, op_IF_ID_PC, op_IF_ID_Instr, 32'(4 * (k - 1)), w);
      else n_pass++;
    end
    n_total++; if (op_IF_ID_RegisterRS1 !== w[19:15] || op_IF_ID_RegisterRS2 !== w[24:20])
      $display("FAIL zw_rs got rs1=%0d rs2=%0d exp rs1=%0d rs2=%0d", op_IF_ID_RegisterRS1, op_IF_ID_RegisterRS2, w[19:15], w[24:20]);
    else n_pass++;
    // Load-use stall with IF/ID at PC 8 and request at 12.
    step(1, 1, 1, 0, 0);
    n_total++; if (op_IF_ID_PC !== 32'd8 || op_IF_ID_Valid !== 1'b1) $display("FAIL lu_hold_pc got pc=%h v=%0h exp pc=00000008 v=1", op_IF_ID_PC, op_IF_ID_Valid); else n_pass++;
    n_total++; if (op_Imem_Addr !== 32'd12 || op_Imem_Req !== 1'b0) $display("FAIL lu_hold_addr got addr=%h req=%0h exp addr=0000000c req=0", op_Imem_Addr, op_Imem_Req); else n_pass++;
    step(1, 0, 0, 0, 0);
    w = mem_word(32'd12);
    n_total++; if (op_IF_ID_PC !== 32'd12 || op_IF_ID_Instr !== w || op_IF_ID_Valid !== 1'b1) $display("FAIL lu_resume12 got pc=%h i=%h exp pc=0000000c i=%h", op_IF_ID_PC, op_IF_ID_Instr, w); else n_pass++;
    n_total++; if (op_Imem_Addr !== 32'd16 || op_Imem_Req !== 1'b1) $display("FAIL lu_addr16 got %h exp 00000010", op_Imem_Addr); else n_pass++;
    step(1, 0, 0, 0, 0);
    n_total++; if (op_IF_ID_PC !== 32'd16 || op_IF_ID_Instr !== mem_word(32'd16)) $display("FAIL lu_resume16 got pc=%h exp 00000010", op_IF_ID_PC); else n_pass++;
  endtask

  task automatic test_hold_buffer();
    logic [31:0] w;
    do_reset();
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    n_total++; if (op_Imem_Req !== 1'b1 || op_Imem_Addr !== 32'd0) $display("FAIL hb_wait_addr got req=%0h addr=%h exp req=1 addr=00000000", op_Imem_Req, op_Imem_Addr); else n_pass++;
    step(1, 1, 1, 0, 0);
    n_total++; if (op_Imem_Req !== 1'b0 || op_IF_ID_Valid !== 1'b0) $display("FAIL hb_hold got req=%0h v=%0h exp req=0 v=0", op_Imem_Req, op_IF_ID_Valid); else n_pass++;
    step(1, 1, 1, 0, 0);
    n_total++; if (op_Imem_Req !== 1'b0) $display("FAIL hb_hold2 got req=%0h exp 0", op_Imem_Req); else n_pass++;
    step(0, 0, 0, 0, 0);
    w = mem_word(32'd0);
    n_total++; if (op_IF_ID_Valid !== 1'b1 || op_IF_ID_PC !== 32'd0 || op_IF_ID_Instr !== w) $display("FAIL hb_release got v=%0h pc=%h i=%h exp v=1 pc=00000000 i=%h", op_IF_ID_Valid, op_IF_ID_PC, op_IF_ID_Instr, w); else n_pass++;
    n_total++; if (op_Imem_Req !== 1'b1 || op_Imem_Addr !== 32'd4) $display("FAIL hb_next_addr got %h exp 00000004", op_Imem_Addr); else n_pass++;
    step(1, 0, 0, 0, 0);
    n_total++; if (op_IF_ID_PC !== 32'd4 || op_IF_ID_Instr !== mem_word(32'd4)) $display("FAIL hb_no_dup got pc=%h exp 00000004", op_IF_ID_PC); else n_pass++;
  endtask

  task automatic test_branch_pending();
    do_reset();
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'h0000_0103);
    n_total++; if (op_IF_ID_Valid !== 1'b0 || op_IF_ID_Instr !== NOP) $display("FAIL bp_flush got v=%0h i=%h exp v=0 i=%h", op_IF_ID_Valid, op_IF_ID_Instr, NOP); else n_pass++;
    n_total++; if (op_Imem_Req !== 1'b1 || op_Imem_Addr !== 32'd4) $display("FAIL bp_old_addr got req=%0h addr=%h exp req=1 addr=00000004", op_Imem_Req, op_Imem_Addr); else n_pass++;
    step(1, 0, 0, 0, 0);
    n_total++; if (op_Imem_Addr !== 32'h100 || op_Imem_Req !== 1'b1) $display("FAIL bp_target got %h exp 00000100", op_Imem_Addr); else n_pass++;
    n_total++; if (op_IF_ID_Valid !== 1'b0) $display("FAIL bp_discard got v=%0h exp 0", op_IF_ID_Valid); else n_pass++;
    step(1, 0, 0, 0, 0);
    n_total++; if (op_IF_ID_Valid !== 1'b1 || op_IF_ID_PC !== 32'h100 || op_IF_ID_Instr !== mem_word(32'h100)) $display("FAIL bp_first got v=%0h pc=%h exp v=1 pc=00000100", op_IF_ID_Valid, op_IF_ID_PC); else n_pass++;
    // Two redirects while the same request is outstanding: the newer wins.
    step(0, 0, 0, 1, 32'h0000_0200);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'h0000_0302);
    step(1, 0, 0, 0, 0);
    n_total++; if (op_Imem_Addr !== 32'h300) $display("FAIL bp_second got %h exp 00000300", op_Imem_Addr); else n_pass++;
  endtask

  task automatic test_branch_stall();
    do_reset();
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 1, 1, 32'h2000_0047);
    n_total++; if (op_IF_ID_Valid !== 1'b0 || op_IF_ID_Instr !== NOP) $display("FAIL bs_flush got v=%0h i=%h exp v=0 i=%h", op_IF_ID_Valid, op_IF_ID_Instr, NOP); else n_pass++;
    n_total++; if (op_Imem_Addr !== 32'h2000_0044 || op_Imem_Req !== 1'b1) $display("FAIL bs_target got %h exp 20000044", op_Imem_Addr); else n_pass++;
    step(1, 1, 1, 0, 0);
    step(0, 1, 1, 1, 32'h0000_0300);
    n_total++; if (op_Imem_Addr !== 32'h300 || op_Imem_Req !== 1'b1) $display("FAIL bs_hold_redirect got req=%0h addr=%h exp req=1 addr=00000300", op_Imem_Req, op_Imem_Addr); else n_pass++;
    step(1, 0, 0, 0, 0);
    n_total++; if (op_IF_ID_PC !== 32'h300 || op_IF_ID_Instr !== mem_word(32'h300) || op_IF_ID_Valid !== 1'b1) $display("FAIL bs_buffer_dropped got pc=%h exp 00000300", op_IF_ID_PC); else n_pass++;
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 32'hFFFF_FFFF);
    n_total++; if (op_Imem_Addr !== 32'hFFFF_FFFC) $display("FAIL wr_top got %h exp fffffffc", op_Imem_Addr); else n_pass++;
    step(1, 0, 0, 0, 0);
    n_total++; if (op_Imem_Addr !== 32'h0) $display("FAIL wr_wrap got %h exp 00000000", op_Imem_Addr); else n_pass++;
    n_total++; if (op_IF_ID_PC !== 32'hFFFF_FFFC || op_IF_ID_Instr !== mem_word(32'hFFFF_FFFC)) $display("FAIL wr_ifid got pc=%h exp fffffffc", op_IF_ID_PC); else n_pass++;
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    ip_rst = 1'b1;
    ip_Imem_Ready = 1'b0;
    @(posedge ip_clk);
    #1;
    n_total++; if (op_Imem_Req !== 1'b0 || op_Imem_Addr !== 32'h0) $display("FAIL wr_midreset got req=%0h addr=%h exp req=0 addr=00000000", op_Imem_Req, op_Imem_Addr); else n_pass++;
    n_total++; if (op_IF_ID_Valid !== 1'b0 || op_IF_ID_Instr !== NOP) $display("FAIL wr_midreset_ifid got v=%0h i=%h exp v=0 i=%h", op_IF_ID_Valid, op_IF_ID_Instr, NOP); else n_pass++;
    ip_rst = 1'b0;
  endtask

  // Random traffic: every instruction ID consumes must be the next one in
  // program order (sequential, restarting at each redirect target).
  task automatic test_random(input int cycles);
    logic [31:0] exp_pc, prev_addr, tgt, w;
    logic        rdy, st, ph, br, prev_br, prev_pend;
    int          consumed;
    do_reset();
    exp_pc = 32'h0; prev_br = 1'b0; prev_pend = 1'b0; prev_addr = '0; consumed = 0;
    for (int c = 0; c < cycles; c++) begin
      if (prev_pend) begin
        n_total++; if (op_Imem_Req !== 1'b1 || op_Imem_Addr !== prev_addr)
          $display("FAIL rnd_addr_stable got req=%0h addr=%h exp req=1 addr=%h", op_Imem_Req, op_Imem_Addr, prev_addr);
        else n_pass++;
      end
      if (op_Imem_Req === 1'b1) begin
        n_total++; if (op_Imem_Addr[1:0] !== 2'b00) $display("FAIL rnd_align got %h exp low bits 00", op_Imem_Addr); else n_pass++;
      end
      if (op_IF_ID_Valid === 1'b1) begin
        w = mem_word(op_IF_ID_PC);
        n_total++; if (op_IF_ID_Instr !== w || op_IF_ID_RegisterRS1 !== w[19:15] || op_IF_ID_RegisterRS2 !== w[24:20])
          $display("FAIL rnd_data got i=%h rs1=%0d rs2=%0d exp i=%h", op_IF_ID_Instr, op_IF_ID_RegisterRS1, op_IF_ID_RegisterRS2, w);
        else n_pass++;
      end else begin
        n_total++; if (op_IF_ID_Instr !== NOP) $display("FAIL rnd_bubble got %h exp %h", op_IF_ID_Instr, NOP); else n_pass++;
      end
      rdy = ($urandom_range(0, 2) != 0);
      st  = ($urandom_range(0, 4) == 0);
      ph  = st | ($urandom_range(0, 15) == 0);
      br  = !prev_br && ($urandom_range(0, 19) == 0);
      tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      if (br) begin
        exp_pc = tgt & 32'hFFFF_FFFC;
      end else if (!st && op_IF_ID_Valid === 1'b1) begin
        n_total++; if (op_IF_ID_PC !== exp_pc) $display("FAIL rnd_order got pc=%h exp %h", op_IF_ID_PC, exp_pc); else n_pass++;
        consumed++;
        exp_pc = exp_pc + 32'd4;
      end
      prev_pend = (op_Imem_Req === 1'b1) && !rdy;
      prev_addr = op_Imem_Addr;
      prev_br   = br;
      step(rdy, st, ph, br, tgt);
    end
    n_total++; if (consumed < cycles / 10) $display("FAIL rnd_progress got %0d exp >= %0d", consumed, cycles / 10); else n_pass++;
  endtask

  initial begin
    ip_clk = 1'b0;
    ip_rst = 1'b1;
    ip_Stall = 1'b0; ip_PC_Hold = 1'b0; ip_Branch_Taken = 1'b0;
    ip_Branch_Target = '0; ip_Imem_Ready = 1'b0; ip_Imem_Data = '0;
    test_reset();
    test_zero_wait();
    test_hold_buffer();
    test_branch_pending();
    test_branch_stall();
    test_wrap_and_reset();
    test_random(3000);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
